// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control FSM: state encoding, ALU operation
// codes and the opcode constants it decodes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StIf    = 3'd0,
        StId    = 3'd1,
        StEx    = 3'd2,
        StMem   = 3'd3,
        StWb    = 3'd4,
        StJwb   = 3'd5,
        StPcinc = 3'd6,
        StHalt  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        AluAdd    = 3'd0,
        AluSub    = 3'd1,
        AluFunct  = 3'd2,
        AluBranch = 3'd3
    } alu_op_e;

    localparam logic [6:0] OpArith    = 7'b0110011;
    localparam logic [6:0] OpArithImm = 7'b0010011;
    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpEcall    = 7'b1110011;

    // Opcodes that have an EX step; ECALL is handled entirely in ID.
    function automatic logic has_ex_step(logic [6:0] op);
        return (op == OpArith) || (op == OpArithImm) || (op == OpLoad) || (op == OpStore) ||
               (op == OpBranch) || (op == OpJal) || (op == OpJalr);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait counter: counts cycles spent in a memory-access state and flags completion,
// either after a fixed latency or when the memory reports ready.
module mem_wait_counter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned HANDSHAKE   = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    input  logic mem_ready_i,
    output logic done_o
);
    localparam int unsigned CntW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("MEM_LATENCY must be at least 1");
    end

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        done_o = (HANDSHAKE != 0) ? mem_ready_i : (count_q == LastCnt);
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control unit: sequences IF/ID/EX/MEM/WB-style steps and drives the
// datapath select lines and register write enables combinationally from the current state.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned HANDSHAKE   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] part_of_inst,
    input  logic       bcond,
    input  logic       ecall_halt,
    input  logic       mem_ready,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic       ALUSrcAWrite,
    output logic       ALUSrcBWrite,
    output logic       ALUOutWrite,
    output logic       PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic [2:0] ALUOp,
    output logic       is_ecall,
    output logic       is_halted
);
    localparam logic [1:0] SrcBReg   = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    in_wait, cnt_done, done;

    assign in_wait = (state_q == StIf) || (state_q == StMem);
    assign done    = in_wait && cnt_done;

    // Any state change restarts the count, so IF and MEM always start at zero.
    mem_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY),
        .HANDSHAKE  (HANDSHAKE)
    ) u_wait (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (state_d != state_q),
        .enable_i   (in_wait),
        .mem_ready_i(mem_ready),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_op       = AluAdd;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SrcBReg;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        MDRWrite     = 1'b0;
        ALUSrcAWrite = 1'b0;
        ALUSrcBWrite = 1'b0;
        ALUOutWrite  = 1'b0;
        PCSource     = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        is_ecall     = 1'b0;
        is_halted    = 1'b0;

        unique case (state_q)
            StIf: begin
                MemRead = 1'b1;
                IRWrite = done;
                if (done) state_d = StId;
            end
            StId: begin
                ALUSrcAWrite = 1'b1;
                ALUSrcBWrite = 1'b1;
                ALUSrcB      = SrcBImm;
                ALUOutWrite  = 1'b1;
                if (part_of_inst == OpEcall) begin
                    is_ecall = 1'b1;
                    state_d  = ecall_halt ? StHalt : StPcinc;
                end else if (has_ex_step(part_of_inst)) begin
                    state_d = StEx;
                end else begin
                    state_d = StPcinc;
                end
            end
            StEx: begin
                state_d = StPcinc;
                if ((part_of_inst == OpArith) || (part_of_inst == OpArithImm)) begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = (part_of_inst == OpArithImm) ? SrcBImm : SrcBReg;
                    alu_op      = AluFunct;
                    ALUOutWrite = 1'b1;
                    state_d     = StWb;
                end else if ((part_of_inst == OpLoad) || (part_of_inst == OpStore)) begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SrcBImm;
                    ALUOutWrite = 1'b1;
                    state_d     = StMem;
                end else if (part_of_inst == OpBranch) begin
                    // Taken branch loads PC from ALUOut (PC+imm computed in ID).
                    ALUSrcA     = 1'b1;
                    alu_op      = AluBranch;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                    state_d     = bcond ? StIf : StPcinc;
                end else if ((part_of_inst == OpJal) || (part_of_inst == OpJalr)) begin
                    ALUSrcB     = SrcBFour;
                    ALUOutWrite = 1'b1;
                    state_d     = StJwb;
                end
            end
            StMem: begin
                IorD = 1'b1;
                if (part_of_inst == OpLoad) begin
                    MemRead  = 1'b1;
                    MDRWrite = done;
                    if (done) state_d = StWb;
                end else begin
                    MemWrite = 1'b1;
                    if (done) state_d = StPcinc;
                end
            end
            StWb: begin
                RegWrite = 1'b1;
                MemtoReg = (part_of_inst == OpLoad);
                ALUSrcB  = SrcBFour;
                PCWrite  = 1'b1;
                state_d  = StIf;
            end
            StJwb: begin
                RegWrite = 1'b1;
                ALUSrcA  = (part_of_inst == OpJalr);
                ALUSrcB  = SrcBImm;
                PCWrite  = 1'b1;
                state_d  = StIf;
            end
            StPcinc: begin
                ALUSrcB = SrcBFour;
                PCWrite = 1'b1;
                state_d = StIf;
            end
            StHalt: begin
                is_halted = 1'b1;
            end
            default: state_d = StIf;
        endcase

        // Nothing architectural may change while reset is held, whatever the state.
        if (reset) begin
            PCWrite      = 1'b0;
            PCWriteCond  = 1'b0;
            RegWrite     = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            MDRWrite     = 1'b0;
            ALUOutWrite  = 1'b0;
            ALUSrcAWrite = 1'b0;
            ALUSrcBWrite = 1'b0;
        end
    end

    assign ALUOp = alu_op;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_LATENCY, default 4, memory access cycles per fetch or data access in fixed mode; SHALL be >=1.
REQ-002 Parameter HANDSHAKE, default 0, memory timing mode: 0 fixed latency counter, 1 wait for mem_ready.
REQ-003 Ports SHALL be, clock and reset first:
 clk  in  1  single clock, rising edge
 reset  in  1  synchronous, active-high
 part_of_inst  in  7  opcode of latched instruction
 bcond  in  1  ALU branch-taken flag
 ecall_halt  in  1  datapath reports x17==10
 mem_ready  in  1  memory access complete (HANDSHAKE=1 only)
 ALUSrcA  out  1  0 PC, 1 reg A
 ALUSrcB  out  2  0 reg B, 1 const 4, 2 imm
 IorD  out  1  0 PC address, 1 ALUOut address
 IRWrite, MDRWrite, ALUSrcAWrite, ALUSrcBWrite, ALUOutWrite  out  1 each  register loads
 PCSource  out  1  0 ALU result, 1 ALUOut
 PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite, MemtoReg  out  1 each
 ALUOp  out  3  ADD, SUB, FUNCT, BRANCH codes
 is_ecall  out  1  ECALL decoded
 is_halted  out  1  FSM in HALT

Function
REQ-004 States SHALL be IF, ID, EX, MEM, WB, JWB, PCINC, HALT, 3-bit encoding; outputs SHALL be combinational from state, opcode, wait counter; undriven outputs 0, ALUSrcB 0, ALUOp ADD.
REQ-005 Wait counter, width clog2(MEM_LATENCY)+1, SHALL clear on entering IF or MEM and increment each cycle there; "done" = count==MEM_LATENCY-1 (HANDSHAKE=0) or mem_ready==1 (HANDSHAKE=1).
REQ-006 IF: MemRead=1, IorD=0 every cycle; IRWrite=1 only on done cycle; IF->ID on done, else stay.
REQ-007 ID: ALUSrcAWrite=ALUSrcBWrite=1; ALUOut<=PC+imm (ALUSrcA=0, ALUSrcB=2, ADD, ALUOutWrite=1); ECALL sets is_ecall=1.
REQ-008 ID transitions: ECALL with ecall_halt -> HALT; ECALL without -> PCINC; unknown opcode -> PCINC; else -> EX.
REQ-009 EX ARITH: ALUSrcA=1, ALUSrcB=0, FUNCT, ALUOutWrite -> WB; ARITH_IMM same with ALUSrcB=2 -> WB.
REQ-010 EX LOAD/STORE: ALUSrcA=1, ALUSrcB=2, ADD, ALUOutWrite -> MEM.
REQ-011 EX BRANCH: ALUSrcA=1, ALUSrcB=0, BRANCH, PCWriteCond=1, PCSource=1; bcond=1 -> IF, bcond=0 -> PCINC.
REQ-012 EX JAL/JALR: ALUOut<=PC+4 (ALUSrcA=0, ALUSrcB=1, ADD, ALUOutWrite) -> JWB.
REQ-013 MEM: IorD=1; LOAD asserts MemRead every cycle, MDRWrite on done, then WB; STORE asserts MemWrite every cycle, then PCINC on done.
REQ-014 WB: RegWrite=1, MemtoReg=1 for LOAD else 0; PC<=PC+4 (ALUSrcA=0, ALUSrcB=1, ADD, PCWrite, PCSource=0) -> IF.
REQ-015 JWB: RegWrite=1, MemtoReg=0; PC<=target via ALU (JAL ALUSrcA=0, JALR ALUSrcA=1; ALUSrcB=2, ADD, PCWrite, PCSource=0) -> IF.
REQ-016 PCINC: PC<=PC+4 as in WB, no RegWrite -> IF.
REQ-017 HALT: all enables 0, is_halted=1, held until reset.
REQ-018 mem_ready SHALL be ignored when HANDSHAKE=0 and outside IF/MEM.

Reset
REQ-019 reset high at clk edge SHALL force state IF, counter 0, regardless of current state, including mid-MEM or HALT.
REQ-020 While reset is high all write enables (PCWrite, PCWriteCond, RegWrite, MemWrite, IRWrite, MDRWrite, ALUOutWrite, ALUSrcAWrite, ALUSrcBWrite) SHALL be 0.

Structure
REQ-021 State encodings, ALUOp codes, opcode constants SHALL live in shared package mc_ctrl_pkg.
REQ-022 Wait counter SHALL be sub-module mem_wait_counter (clear, enable, done).

Verification
REQ-023 MEM_LATENCY=4, HANDSHAKE=0, ADD: IF 4 cycles, IRWrite only in 4th, ID, EX, WB with RegWrite+PCWrite; 7 cycles total.
REQ-024 HANDSHAKE=1, LOAD, mem_ready after 2 and 5 cycles: IRWrite and MDRWrite on ready cycles, MemtoReg=1 in WB.
REQ-025 BRANCH bcond=1 -> EX to IF, PCWriteCond=1; bcond=0 -> PCINC PCWrite=1 PCSource=0.
REQ-026 ECALL ecall_halt=1 -> HALT, is_halted=1 for 20 cycles; ecall_halt=0 -> PCINC.
REQ-027 reset asserted during 2nd MEM cycle of STORE -> next state IF, counter 0, MemWrite 0 during reset.
REQ-028 MEM_LATENCY=1: IF and MEM last exactly one cycle each; JAL passes IF, ID, EX, JWB.
